// File: rtl/floo_clint_pkg.sv
// Shared definitions for the CLINT register block: address map, FSM states,
// register-bus request/response structs and the byte-strobe merge helper.
package floo_clint_pkg;

  localparam int unsigned RegAddrW = 32;

  localparam logic [31:0] MsipOffset     = 32'h0000_0000;
  localparam logic [31:0] MtimecmpOffset = 32'h0000_4000;
  localparam logic [31:0] MtimeLoOffset  = 32'h0000_BFF8;
  localparam logic [31:0] MtimeHiOffset  = 32'h0000_BFFC;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StResp = 1'b1
  } clint_state_e;

  typedef struct packed {
    logic                write;
    logic [RegAddrW-1:0] addr;
    logic [31:0]         wdata;
    logic [3:0]          strb;
  } clint_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } clint_rsp_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/floo_clint_timer.sv
// 64-bit mtime timebase, per-hart mtimecmp registers and registered mtip
// comparators. Only instantiated when FLOO_CLINT_MTIME_EN is defined.
module floo_clint_timer
  import floo_clint_pkg::*;
#(
  parameter int unsigned NumCores = 9,
  parameter int unsigned IdxW     = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic                cmp_we_i,
  input  logic                mtime_we_i,
  input  logic                cmp_sel_i,
  input  logic                hi_i,
  input  logic [IdxW-1:0]     idx_i,
  input  logic [31:0]         wdata_i,
  input  logic [3:0]          strb_i,
  output logic [31:0]         rdata_o,
  output logic [NumCores-1:0] mtip_o
);

  logic [63:0]               mtime_q, mtime_d;
  logic [NumCores-1:0][63:0] cmp_q, cmp_d;
  logic [NumCores-1:0]       mtip_q, mtip_d;

  // A bus write to either mtime word takes priority and suppresses the tick.
  always_comb begin
    mtime_d = mtime_q;
    if (mtime_we_i) begin
      if (hi_i) mtime_d[63:32] = strb_merge(mtime_q[63:32], wdata_i, strb_i);
      else      mtime_d[31:0]  = strb_merge(mtime_q[31:0], wdata_i, strb_i);
    end else if (tick_i) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    if (cmp_we_i) begin
      if (hi_i) cmp_d[idx_i][63:32] = strb_merge(cmp_q[idx_i][63:32], wdata_i, strb_i);
      else      cmp_d[idx_i][31:0]  = strb_merge(cmp_q[idx_i][31:0], wdata_i, strb_i);
    end
  end

  always_comb begin
    mtip_d = '0;
    for (int i = 0; i < NumCores; i++) mtip_d[i] = (mtime_q >= cmp_q[i]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q <= '0;
      cmp_q   <= '1;
      mtip_q  <= '0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      mtip_q  <= mtip_d;
    end
  end

  always_comb begin
    if (cmp_sel_i) rdata_o = hi_i ? cmp_q[idx_i][63:32] : cmp_q[idx_i][31:0];
    else           rdata_o = hi_i ? mtime_q[63:32] : mtime_q[31:0];
  end

  assign mtip_o = mtip_q;

endmodule

// File: rtl/floo_clint_ctrl.sv
// CLINT register-bus front end: two-state request/response FSM, msip registers
// and address decode. Timer support is enabled by defining FLOO_CLINT_MTIME_EN.
module floo_clint_ctrl
  import floo_clint_pkg::*;
#(
  parameter int unsigned NumCores  = 9,
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_strb_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_error_o,
  input  logic                 rtc_tick_i,
  output logic [NumCores-1:0]  msip_o,
  output logic [NumCores-1:0]  mtip_o
);

  localparam int unsigned IdxW = (NumCores > 1) ? $clog2(NumCores) : 1;

  if (DataWidth != 32) begin : g_bad_dw
    $error("floo_clint_ctrl supports DataWidth = 32 only");
  end

  clint_state_e        state_q, state_d;
  clint_req_t          req;
  clint_rsp_t          rsp_d, rsp_q;
  logic [NumCores-1:0] msip_q, msip_d;
  logic [NumCores-1:0] mtip;
  logic [IdxW-1:0]     msip_idx;
  logic [31:0]         timer_rdata;
  logic                accept, aligned, msip_hit, cmp_hit, mtime_hit;

  assign req = '{write: req_write_i, addr: RegAddrW'(req_addr_i),
                 wdata: req_wdata_i, strb: req_strb_i};

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign accept      = req_ready_o && req_valid_i;

  assign aligned  = (req.addr[1:0] == 2'b00);
  assign msip_hit = aligned && (req.addr < MsipOffset + 32'(4 * NumCores));
  assign msip_idx = IdxW'((req.addr - MsipOffset) >> 2);

`ifdef FLOO_CLINT_MTIME_EN
  logic [31:0]     cmp_off;
  logic [IdxW-1:0] cmp_idx;

  assign cmp_off   = req.addr - MtimecmpOffset;
  assign cmp_idx   = IdxW'(cmp_off >> 3);
  assign cmp_hit   = aligned && (req.addr >= MtimecmpOffset) &&
                     (req.addr < MtimecmpOffset + 32'(8 * NumCores));
  assign mtime_hit = aligned && ((req.addr == MtimeLoOffset) || (req.addr == MtimeHiOffset));

  floo_clint_timer #(
    .NumCores (NumCores),
    .IdxW     (IdxW)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tick_i     (rtc_tick_i),
    .cmp_we_i   (accept && req.write && cmp_hit),
    .mtime_we_i (accept && req.write && mtime_hit),
    .cmp_sel_i  (cmp_hit),
    .hi_i       (req.addr[2]),
    .idx_i      (cmp_idx),
    .wdata_i    (req.wdata),
    .strb_i     (req.strb),
    .rdata_o    (timer_rdata),
    .mtip_o     (mtip)
  );
`else
  // Without the timer the whole 0x4000-0xBFFF window decodes as unmapped.
  logic unused_timer;
  assign unused_timer = ^{rtc_tick_i, req.wdata[31:1], req.strb[3:1]};
  assign cmp_hit      = 1'b0;
  assign mtime_hit    = 1'b0;
  assign timer_rdata  = '0;
  assign mtip         = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_valid_i) state_d = StResp;
      StResp:  if (rsp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Writes return rdata 0; errored accesses return 0 and touch nothing.
  always_comb begin
    rsp_d = '{rdata: '0, error: 1'b0};
    if (!(msip_hit || cmp_hit || mtime_hit)) begin
      rsp_d.error = 1'b1;
    end else if (!req.write) begin
      if (msip_hit) rsp_d.rdata = {31'b0, msip_q[msip_idx]};
      else          rsp_d.rdata = timer_rdata;
    end
  end

  always_comb begin
    msip_d = msip_q;
    if (accept && req.write && msip_hit && req.strb[0]) msip_d[msip_idx] = req.wdata[0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      rsp_q   <= '0;
      msip_q  <= '0;
    end else begin
      state_q <= state_d;
      msip_q  <= msip_d;
      if (accept) rsp_q <= rsp_d;
    end
  end

  assign rsp_rdata_o = rsp_q.rdata;
  assign rsp_error_o = rsp_q.error;
  assign msip_o      = msip_q;
  assign mtip_o      = mtip;

endmodule

// File: doc/floo_clint_ctrl.md
FLOO_CLINT_CTRL -- requirements
Module: floo_clint_ctrl

Interface
REQ-001 SHALL have parameter NumCores, default 9, giving the number of harts served.
REQ-002 SHALL have parameter AddrWidth, default 16, giving the register-bus address width.
REQ-003 SHALL have parameter DataWidth, default 32, giving the register-bus data width; only 32 is supported.
REQ-004 SHALL have clk_i  in  1  the single clock; all logic rises on its posedge.
REQ-005 SHALL have rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have req_valid_i  in  1  request valid; req_ready_o  out  1  request accepted when both high.
REQ-007 SHALL have req_write_i  in  1  1 = write, 0 = read.
REQ-008 SHALL have req_addr_i  in  AddrWidth  byte address; req_wdata_i  in  32  write data; req_strb_i  in  4  byte enables.
REQ-009 SHALL have rsp_valid_o  out  1  response valid; rsp_ready_i  in  1  response taken when both high.
REQ-010 SHALL have rsp_rdata_o  out  32  read data; rsp_error_o  out  1  access error.
REQ-011 SHALL have rtc_tick_i  in  1  timebase enable, one mtime increment per high cycle.
REQ-012 SHALL have msip_o  out  NumCores  software interrupt per hart; mtip_o  out  NumCores  timer interrupt per hart.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (req_ready_o=1, rsp_valid_o=0) and RESP (req_ready_o=0, rsp_valid_o=1).
REQ-014 SHALL move IDLE->RESP on req_valid_i; RESP->IDLE on rsp_ready_i; hold RESP with stable rsp_rdata_o/rsp_error_o while rsp_ready_i=0.
REQ-015 SHALL give response latency of exactly one cycle after acceptance, and sustain one access per two cycles.
REQ-016 SHALL apply writes at the acceptance edge, honouring req_strb_i per byte.
REQ-017 SHALL map msip[i] at 0x0000+4*i, bit 0 only; other bits read 0 and ignore writes.
REQ-018 SHALL map mtimecmp[i] at 0x4000+8*i (low word) and 0x4004+8*i (high word).
REQ-019 SHALL map mtime at 0xBFF8 (low) and 0xBFFC (high).
REQ-020 SHALL flag rsp_error_o=1 for unmapped or misaligned (addr[1:0]!=0) accesses; such reads return 0 and such writes are dropped.
REQ-021 SHALL increment 64-bit mtime by 1 per cycle with rtc_tick_i=1, wrapping 0xFFFF_FFFF_FFFF_FFFF->0.
REQ-022 SHALL let a same-cycle mtime write win over a tick; the written word is stored and no increment occurs that cycle.
REQ-023 SHALL register mtip_o[i] = (mtime >= mtimecmp[i]), unsigned, one cycle after either operand changes.
REQ-024 SHALL drive msip_o directly from the msip registers, visible the cycle after the write.

Reset
REQ-025 SHALL on rst_i force FSM=IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, msip=0, mtime=0, mtimecmp=all ones, mtip_o=0.
REQ-026 SHALL abandon a pending response when reset is asserted in RESP, with no write replayed after release.

Configuration
REQ-027 SHALL with FLOO_CLINT_MTIME_EN defined implement mtime, mtimecmp, rtc_tick_i and mtip_o as specified.
REQ-028 SHALL without FLOO_CLINT_MTIME_EN tie mtip_o to 0, ignore rtc_tick_i, and treat the 0x4000-0xBFFF range as unmapped (error).

Structure
REQ-029 SHALL place address offsets, the FSM state enum and the register-bus request/response structs in package floo_clint_pkg.
REQ-030 SHALL isolate mtime/mtimecmp/mtip in sub-module floo_clint_timer, instantiated only under FLOO_CLINT_MTIME_EN.

Verification
REQ-031 SHALL cover: write 0x1 to 0x0008 -> msip_o[2]=1 next cycle; read 0x0008 -> rdata=0x1, error=0.
REQ-032 SHALL cover: mtimecmp[0]=5, mtime=0, rtc_tick_i held high -> mtip_o[0] rises on the cycle after mtime reaches 5.
REQ-033 SHALL cover: mtime low write 0xFFFF_FFFF with tick same cycle -> low word reads 0xFFFF_FFFF; the next tick carries, giving high word +1 and low word 0.
REQ-034 SHALL cover: read 0x0002 and read 0xC000 -> error=1, rdata=0, no state change.
REQ-035 SHALL cover: rsp_ready_i held low 10 cycles -> rsp_valid_o and rdata stable, req_ready_o=0 throughout.
REQ-036 SHALL cover: rst_i pulsed while in RESP after an msip write -> rsp_valid_o=0, msip_o=0, mtip_o=0 after reset.
